// File: rtl/ras_stack.sv
// Return-address stack: circular register file with wrapping SP and saturating count.
// Define RAS_WRAP_EN to let a push while full overwrite the oldest entry (default: drop it).
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PUSH,
  input  logic        POP,
  input  logic [31:0] PUSH_ADDR,
  output logic [31:0] TOP,
  output logic        EMPTY,
  output logic        FULL,
  output logic        UNDERFLOW,
  output logic        OVERFLOW
);

`ifdef RAS_WRAP_EN
  localparam bit LP_WRAP = 1'b1;
`else
  localparam bit LP_WRAP = 1'b0;
`endif
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] r_mem;
  logic [PTR_W-1:0]       r_sp;
  logic [PTR_W:0]         r_cnt;
  logic                   r_underflow, r_overflow;

  logic [PTR_W-1:0] w_sp_inc, w_sp_dec;
  logic             w_empty, w_full;
  logic             w_do_push, w_do_pop, w_do_repl;

  assign w_sp_inc = r_sp + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == LP_DEPTH);

  // Push+pop on an empty stack degenerates to a plain push.
  assign w_do_push = PUSH && (!POP || w_empty) && (!w_full || LP_WRAP || POP);
  assign w_do_pop  = POP && !PUSH && !w_empty;
  assign w_do_repl = PUSH && POP && !w_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mem       <= '0;
      r_sp        <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_underflow <= POP && !PUSH && w_empty;
      r_overflow  <= PUSH && !POP && w_full;
      if (w_do_push) begin
        r_sp            <= w_sp_inc;
        r_mem[w_sp_inc] <= PUSH_ADDR;
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end else if (w_do_pop) begin
        r_sp  <= w_sp_dec;
        r_cnt <= r_cnt - 1'b1;
      end else if (w_do_repl) begin
        r_mem[r_sp] <= PUSH_ADDR;
      end
    end
  end

  // Registered-state only: fetch can consume TOP in the same cycle it asserts POP.
  assign TOP       = w_empty ? 32'h0 : r_mem[r_sp];
  assign EMPTY     = w_empty;
  assign FULL      = w_full;
  assign UNDERFLOW = r_underflow;
  assign OVERFLOW  = r_overflow;

endmodule
